dbg_link_master: RTL and testbench

DBG_LINK_MASTER -- requirements
Module: dbg_link_master

---
 rtl/dbg_link_pkg.sv | 29 ++
 rtl/dbg_link_master.sv | 199 +++++++++++++++++++
 tb/tb_dbg_link_master.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_link_pkg.sv
// rtl/dbg_link_pkg.sv - shared types and constants for the debug link master
//
// Purpose: FSM state encoding, the no-command code and frame byte counts
//          used by dbg_link_master.
// Ports:   none (package).

package dbg_link_pkg;

  typedef enum logic [2:0] {
    ST_RX_CMD   = 3'd0,
    ST_RX_ADDR  = 3'd1,
    ST_RX_DATA  = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_WAIT_RDY = 3'd4,
    ST_TX_RESP  = 3'd5
  } state_e;

  localparam logic [7:0] CMD_NOP = 8'h00;

  localparam int ADDR_BYTES = 4;
  localparam int DATA_BYTES = 4;
  localparam int RESP_BYTES = 4;

  // Byte-lane index of the final byte of a multi-byte field.
  function automatic logic [1:0] last_lane(input int nbytes);
    return 2'(nbytes - 1);
  endfunction

endpackage

// File: rtl/dbg_link_master.sv
// rtl/dbg_link_master.sv - byte-stream to debug-bus bridge with timeout
//
// Purpose: receives 9-byte frames (cmd, addr[4], data[4], little-endian) on
//          the rx stream, issues the command to a debug module, waits for its
//          completion strobe (or a timeout) and returns a 4-byte response on
//          the tx stream. A cmd byte of 8'h00 is consumed and dropped.
// Ports:
//   clk          clock, all state on rising edge
//   rst_i        synchronous active-high reset
//   rx_data_i    inbound byte          rx_valid_i / rx_ready_o handshake
//   tx_data_o    outbound byte         tx_valid_o / tx_ready_i handshake
//   dbg_cmd_o    debug command (8'h00 = none)
//   dbg_addr_o   debug address
//   dbg_data_o   debug write data
//   dbg_data_i   debug read data, sampled with dbg_ready_i
//   dbg_ready_i  debug completion strobe
//   busy_o       high whenever not waiting for a command byte
//   timeout_o    sticky command-timeout flag, cleared only by reset

module dbg_link_master
  import dbg_link_pkg::*;
#(
  parameter int unsigned   TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]   TIMEOUT_WORD   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned     WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [WAIT_W-1:0]  wait_inc;
  logic [7:0]         cmd_q, cmd_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [7:0]         dbg_cmd_q, dbg_cmd_d;
  logic [31:0]        dbg_addr_q, dbg_addr_d;
  logic [31:0]        dbg_data_q, dbg_data_d;
  logic [31:0]        resp_q, resp_d;
  logic               timeout_q, timeout_d;
  logic               rx_take;

  // rx_ready_o is forced low during the reset cycle, so a byte presented
  // then is never counted as taken.
  assign rx_take  = rx_valid_i & ~rst_i;
  assign wait_inc = wait_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    dbg_cmd_d  = dbg_cmd_q;
    dbg_addr_d = dbg_addr_q;
    dbg_data_d = dbg_data_q;
    resp_d     = resp_q;
    timeout_d  = timeout_q;
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;

    case (state_q)
      ST_RX_CMD: begin
        rx_ready_o = ~rst_i;
        if (rx_take) begin
          cmd_d = rx_data_i;
          cnt_d = 2'd0;
          if (rx_data_i != CMD_NOP) begin
            state_d = ST_RX_ADDR;
          end
        end
      end

      ST_RX_ADDR: begin
        rx_ready_o = ~rst_i;
        if (rx_take) begin
          addr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_lane(ADDR_BYTES)) begin
            state_d = ST_RX_DATA;
          end
        end
      end

      ST_RX_DATA: begin
        rx_ready_o = ~rst_i;
        if (rx_take) begin
          data_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_lane(DATA_BYTES)) begin
            // Present the whole frame to the debug bus from the next cycle;
            // data_d already holds the byte arriving on this edge.
            state_d    = ST_ISSUE;
            dbg_cmd_d  = cmd_q;
            dbg_addr_d = addr_q;
            dbg_data_d = data_d;
            wait_d     = '0;
          end
        end
      end

      ST_ISSUE: begin
        wait_d = '0;
        if (dbg_ready_i) begin
          resp_d    = dbg_data_i;
          dbg_cmd_d = CMD_NOP;
          state_d   = ST_TX_RESP;
        end else begin
          state_d   = ST_WAIT_RDY;
        end
      end

      ST_WAIT_RDY: begin
        wait_d = wait_inc;
        // A completion arriving on the expiry cycle still counts as success.
        if (dbg_ready_i) begin
          resp_d    = dbg_data_i;
          dbg_cmd_d = CMD_NOP;
          state_d   = ST_TX_RESP;
        end else if (wait_inc == WAIT_LIMIT) begin
          resp_d    = TIMEOUT_WORD;
          timeout_d = 1'b1;
          dbg_cmd_d = CMD_NOP;
          state_d   = ST_TX_RESP;
        end
      end

      ST_TX_RESP: begin
        tx_valid_o = 1'b1;
        tx_data_o  = resp_q[{cnt_q, 3'b000} +: 8];
        if (tx_ready_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_lane(RESP_BYTES)) begin
            state_d = ST_RX_CMD;
          end
        end
      end

      default: begin
        state_d = ST_RX_CMD;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= ST_RX_CMD;
      cnt_q      <= 2'd0;
      wait_q     <= '0;
      cmd_q      <= CMD_NOP;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      dbg_cmd_q  <= CMD_NOP;
      dbg_addr_q <= 32'h0;
      dbg_data_q <= 32'h0;
      resp_q     <= 32'h0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      dbg_cmd_q  <= dbg_cmd_d;
      dbg_addr_q <= dbg_addr_d;
      dbg_data_q <= dbg_data_d;
      resp_q     <= resp_d;
      timeout_q  <= timeout_d;
    end
  end

  assign dbg_cmd_o  = dbg_cmd_q;
  assign dbg_addr_o = dbg_addr_q;
  assign dbg_data_o = dbg_data_q;
  assign timeout_o  = timeout_q;
  assign busy_o     = (state_q != ST_RX_CMD);

endmodule

// File: tb/tb_dbg_link_master.sv
// tb/tb_dbg_link_master.sv - scoreboard bench for dbg_link_master
//
// Purpose: drives frames on the rx stream, answers debug commands with a
//          scripted responder and checks debug-bus activity and tx bytes
//          against queued expectations from a frame-level model.
// Ports:   none (top-level bench).

module tb_dbg_link_master;

  localparam int          TOUT  = 8;
  localparam logic [31:0] TWORD = 32'hDEADBEEF;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    int          d;
    logic [31:0] rdata;
  } dbg_exp_t;

  logic        clk;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic [31:0] dbg_data_i;
  logic        dbg_ready_i;
  logic        busy_o;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;
  bit tgl_mode = 1'b1;

  dbg_exp_t   mon_q[$];
  dbg_exp_t   rsp_q[$];
  logic [7:0] tx_q[$];

  dbg_link_master #(
    .TIMEOUT_CYCLES(TOUT),
    .TIMEOUT_WORD  (TWORD)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .dbg_cmd_o  (dbg_cmd_o),
    .dbg_addr_o (dbg_addr_o),
    .dbg_data_o (dbg_data_o),
    .dbg_data_i (dbg_data_i),
    .dbg_ready_i(dbg_ready_i),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endfunction

  // tx sink readiness, changed just after the rising edge.
  initial begin
    tx_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tgl_mode) tx_ready_i = ~tx_ready_i;
      else          tx_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Debug responder: completes each command d cycles after ISSUE with the
  // scripted read data; idle cycles carry random noise on the strobe.
  initial begin
    dbg_exp_t r;
    int k;
    int n;
    dbg_ready_i = 1'b0;
    dbg_data_i  = 32'h0;
    forever begin
      @(negedge clk);
      if (dbg_cmd_o != 8'h00 && !rst_i && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        k = 0;
        while (k < r.d && dbg_cmd_o != 8'h00) begin
          dbg_ready_i = 1'b0;
          dbg_data_i  = $urandom;
          @(negedge clk);
          k++;
        end
        if (dbg_cmd_o != 8'h00) begin
          dbg_ready_i = 1'b1;
          dbg_data_i  = r.rdata;
          @(negedge clk);
        end
        dbg_ready_i = 1'b0;
        n = 0;
        while (dbg_cmd_o != 8'h00 && n < 100) begin
          @(negedge clk);
          n++;
        end
      end else begin
        dbg_ready_i = ($urandom_range(0, 3) == 0);
        dbg_data_i  = $urandom;
      end
    end
  end

  // Debug-bus monitor: checks issued fields, how long the command is held,
  // that addr/data persist afterwards and the sticky timeout flag.
  dbg_exp_t cur;
  bit       active = 1'b0;
  bit       sticky = 1'b0;
  int       cmd_len = 0;
  int       exp_len;
  always @(negedge clk) begin
    if (rst_i) begin
      active = 1'b0;
      sticky = 1'b0;
    end else if (!active && dbg_cmd_o != 8'h00) begin
      if (mon_q.size() == 0) begin
        chk("dbg_unexpected_cmd", 32'(dbg_cmd_o), 32'h0);
      end else begin
        cur = mon_q.pop_front();
        chk("dbg_cmd", 32'(dbg_cmd_o), 32'(cur.cmd));
        chk("dbg_addr", dbg_addr_o, cur.addr);
        chk("dbg_data", dbg_data_o, cur.data);
        active  = 1'b1;
        cmd_len = 1;
      end
    end else if (active && dbg_cmd_o != 8'h00) begin
      cmd_len++;
    end else if (active) begin
      active  = 1'b0;
      exp_len = ((cur.d <= TOUT) ? cur.d : TOUT) + 1;
      chk("dbg_cmd_len", 32'(cmd_len), 32'(exp_len));
      chk("dbg_addr_hold", dbg_addr_o, cur.addr);
      chk("dbg_data_hold", dbg_data_o, cur.data);
      if (cur.d > TOUT) sticky = 1'b1;
      chk("timeout_flag", 32'(timeout_o), 32'(sticky));
    end
  end

  // tx monitor: order/content against the queue, stability while stalled.
  bit         stalled = 1'b0;
  logic [7:0] held;
  logic [7:0] exp_b;
  always @(negedge clk) begin
    if (rst_i) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("tx_valid_hold", 32'(tx_valid_o), 32'h1);
        chk("tx_data_stable", 32'(tx_data_o), 32'(held));
      end
      stalled = 1'b0;
      if (tx_valid_o) begin
        chk("rx_ready_in_tx", 32'(rx_ready_o), 32'h0);
        if (tx_ready_i) begin
          if (tx_q.size() == 0) begin
            chk("tx_unexpected_byte", 32'(tx_data_o) | 32'h100, 32'h0);
          end else begin
            exp_b = tx_q.pop_front();
            chk("tx_byte", 32'(tx_data_o), 32'(exp_b));
          end
        end else begin
          stalled = 1'b1;
          held    = tx_data_o;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    n = 0;
    while (!rx_ready_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      errors++;
      checks++;
      $display("FAIL rx_accept: got=no_ready expected=ready within 5000 cycles");
    end
    @(negedge clk);
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  // Frame-level model: response is the read data when the responder
  // answers within TOUT wait cycles, the timeout word otherwise.
  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int d,
                            input logic [31:0] rdata);
    dbg_exp_t    e;
    logic [31:0] resp;
    send_byte(cmd);
    if (cmd == 8'h00) return;
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    e.cmd = cmd; e.addr = addr; e.data = data; e.d = d; e.rdata = rdata;
    resp = (d <= TOUT) ? rdata : TWORD;
    mon_q.push_back(e);
    rsp_q.push_back(e);
    for (int i = 0; i < 4; i++) tx_q.push_back(resp[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((busy_o || tx_q.size() != 0 || mon_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      errors++;
      checks++;
      $display("FAIL idle_wait: got=busy expected=idle within 3000 cycles");
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    chk("rx_ready_in_reset", 32'(rx_ready_o), 32'h0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_dbg_cmd", 32'(dbg_cmd_o), 32'h0);
    chk("rst_dbg_addr", dbg_addr_o, 32'h0);
    chk("rst_dbg_data", dbg_data_o, 32'h0);
    chk("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    chk("rst_tx_data", 32'(tx_data_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    chk("rst_rx_ready", 32'(rx_ready_o), 32'h1);
  endtask

  initial begin
    logic [7:0] c;
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    do_reset();

    send_frame(8'h02, 32'h0000_4100, 32'hDEAD_BEEF, 3, 32'h0000_0000);
    send_frame(8'h01, 32'h0000_0004, 32'h0000_0000, 1, 32'h1234_5678);
    send_frame(8'h03, 32'h1000_0000, 32'h0000_5A5A, TOUT, 32'hCAFE_0001);
    wait_idle();
    chk("timeout_clear_at_limit", 32'(timeout_o), 32'h0);
    send_frame(8'h01, 32'h0000_0020, 32'h0000_0000, 1000, 32'h5555_5555);
    send_frame(8'h01, 32'h0000_0024, 32'h0000_0000, 2, 32'h0102_0304);
    wait_idle();
    chk("timeout_sticky", 32'(timeout_o), 32'h1);

    send_byte(8'h00);
    send_frame(8'h01, 32'h0000_0008, 32'h0000_0000, 0, 32'hA5A5_0F0F);
    wait_idle();

    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    do_reset();
    send_frame(8'h02, 32'h8765_4321, 32'h1111_2222, 4, 32'h0BAD_F00D);
    wait_idle();

    tgl_mode = 1'b0;
    repeat (40) begin
      c = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      send_frame(c, $urandom, $urandom, $urandom_range(0, TOUT + 3), $urandom);
    end
    wait_idle();
    chk("tx_queue_drained", 32'(tx_q.size()), 32'h0);
    chk("dbg_queue_drained", 32'(mon_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
